// File: rtl/axis_packer.sv
// AXI-Stream width up-converter: packs WORD_W-bit input words into WORDS_PER_BEAT
// lanes of one output beat, lane 0 first, with per-lane keep and packet last.
module axis_packer #(
  parameter int WORD_W         = 8,
  parameter int BUS_W          = 32,
  parameter int WORDS_PER_BEAT = BUS_W / WORD_W
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic                                   s_last,
  input  logic [WORD_W-1:0]                      s_data,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic                                   m_last,
  output logic [WORDS_PER_BEAT-1:0]              m_keep,
  output logic [WORDS_PER_BEAT-1:0][WORD_W-1:0]  m_data
);

  if ((BUS_W % WORD_W) != 0) begin : g_bad_width
    $fatal(1, "axis_packer: BUS_W must be a multiple of WORD_W");
  end

  localparam int LANE_W = (WORDS_PER_BEAT > 1) ? $clog2(WORDS_PER_BEAT) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORDS_PER_BEAT - 1);

  logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] r_fill;
  logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] r_data;
  logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] w_beat_data;
  logic [WORDS_PER_BEAT-1:0]             r_keep;
  logic [WORDS_PER_BEAT-1:0]             w_beat_keep;
  logic [LANE_W-1:0]                     r_lane;
  logic                                  r_valid;
  logic                                  r_last;
  logic                                  w_accept;
  logic                                  w_complete;

  assign s_ready    = !r_valid || m_ready;
  assign w_accept   = s_valid && s_ready;
  assign w_complete = w_accept && ((r_lane == LAST_LANE) || s_last);

  // Lanes above the current index are already zero because the fill buffer
  // is cleared whenever a beat leaves it.
  always_comb begin
    w_beat_data = r_fill;
    w_beat_keep = '0;
    for (int unsigned i = 0; i < WORDS_PER_BEAT; i++) begin
      if (LANE_W'(i) == r_lane) w_beat_data[i] = s_data;
      if (LANE_W'(i) <= r_lane) w_beat_keep[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill  <= '0;
      r_lane  <= '0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      if (w_complete) begin
        r_data  <= w_beat_data;
        r_keep  <= w_beat_keep;
        r_last  <= s_last;
        r_valid <= 1'b1;
        r_fill  <= '0;
        r_lane  <= '0;
      end else begin
        if (w_accept) begin
          r_fill[r_lane] <= s_data;
          r_lane         <= r_lane + LANE_W'(1);
        end
        if (m_ready) r_valid <= 1'b0;
      end
    end
  end

  assign m_valid = r_valid;
  assign m_data  = r_data;
  assign m_keep  = r_keep;
  assign m_last  = r_last;

endmodule
